// File: rtl/ex_mem_reg_if.sv
// EX/MEM boundary bus: EX-side instruction fields, MEM/WB writeback bus and registered MEM-side outputs.
// The master drives the EX side and observes MEM; the slave is the pipeline register itself.
interface ex_mem_reg_if #(
    parameter int DW = 16,
    parameter int RW = 4
);
    logic          stall;
    logic          flush;

    logic          ex_valid;
    logic [DW-1:0] ex_alu_result;
    logic [DW-1:0] ex_rt_data;
    logic [RW-1:0] ex_rt_addr;
    logic [RW-1:0] ex_rd_addr;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_reg_write;
    logic          ex_mem_to_reg;
    logic          ex_halt;
    logic [DW-1:0] ex_pc_plus2;

    logic          wb_reg_write;
    logic [RW-1:0] wb_rd_addr;
    logic [DW-1:0] wb_data;

    logic          mem_valid;
    logic          mem_mem_read;
    logic          mem_mem_write;
    logic          mem_reg_write;
    logic          mem_mem_to_reg;
    logic [DW-1:0] mem_alu_result;
    logic [DW-1:0] mem_store_data;
    logic [RW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_pc_plus2;
    logic          mem_misalign;
    logic          halted;

    modport master (
        output stall, flush,
        output ex_valid, ex_alu_result, ex_rt_data, ex_rt_addr, ex_rd_addr,
        output ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_halt, ex_pc_plus2,
        output wb_reg_write, wb_rd_addr, wb_data,
        input  mem_valid, mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg,
        input  mem_alu_result, mem_store_data, mem_rd_addr, mem_pc_plus2, mem_misalign, halted
    );

    modport slave (
        input  stall, flush,
        input  ex_valid, ex_alu_result, ex_rt_data, ex_rt_addr, ex_rd_addr,
        input  ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_halt, ex_pc_plus2,
        input  wb_reg_write, wb_rd_addr, wb_data,
        output mem_valid, mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg,
        output mem_alu_result, mem_store_data, mem_rd_addr, mem_pc_plus2, mem_misalign, halted
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register, 1-cycle latency; priority rst > flush > stall > load, sticky halt freezes loads.
// Define EXMEM_STORE_FWD_EN to forward the WB bus into store data when it targets the store's rt register.
module ex_mem_reg #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic         clk,
    input  logic         rst,
    ex_mem_reg_if.slave  bus
);
    logic          r_mem_valid;
    logic          r_mem_mem_read;
    logic          r_mem_mem_write;
    logic          r_mem_reg_write;
    logic          r_mem_mem_to_reg;
    logic [DW-1:0] r_mem_alu_result;
    logic [DW-1:0] r_mem_store_data;
    logic [RW-1:0] r_mem_rd_addr;
    logic [DW-1:0] r_mem_pc_plus2;
    logic          r_mem_misalign;
    logic          r_halted;

    logic          w_load;
    logic          w_mem_read;
    logic          w_mem_write;
    logic          w_reg_write;
    logic          w_misalign;
    logic          w_halt_set;
    logic [DW-1:0] w_store_data;

    // Once halted the slot is frozen; only reset releases it.
    assign w_load      = !bus.stall && !r_halted;
    assign w_mem_read  = bus.ex_valid & bus.ex_mem_read;
    assign w_mem_write = bus.ex_valid & bus.ex_mem_write;
    assign w_reg_write = bus.ex_valid & bus.ex_reg_write & (bus.ex_rd_addr != '0);
    assign w_misalign  = bus.ex_valid & (bus.ex_mem_read | bus.ex_mem_write) & bus.ex_alu_result[0];
    assign w_halt_set  = bus.ex_valid & bus.ex_halt;

`ifdef EXMEM_STORE_FWD_EN
    logic w_fwd_hit;

    assign w_fwd_hit    = bus.wb_reg_write & (bus.wb_rd_addr == bus.ex_rt_addr)
                        & (bus.ex_rt_addr != '0) & bus.ex_mem_write;
    assign w_store_data = w_fwd_hit ? bus.wb_data : bus.ex_rt_data;
`else
    logic w_wb_unused;

    assign w_store_data = bus.ex_rt_data;
    assign w_wb_unused  = ^{bus.wb_reg_write, bus.wb_rd_addr, bus.wb_data, bus.ex_rt_addr};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_valid      <= 1'b0;
            r_mem_mem_read   <= 1'b0;
            r_mem_mem_write  <= 1'b0;
            r_mem_reg_write  <= 1'b0;
            r_mem_mem_to_reg <= 1'b0;
            r_mem_alu_result <= '0;
            r_mem_store_data <= '0;
            r_mem_rd_addr    <= '0;
            r_mem_pc_plus2   <= '0;
            r_mem_misalign   <= 1'b0;
            r_halted         <= 1'b0;
        end else if (bus.flush) begin
            // Bubble: kill the slot's side effects, leave data and halt state alone.
            r_mem_valid      <= 1'b0;
            r_mem_mem_read   <= 1'b0;
            r_mem_mem_write  <= 1'b0;
            r_mem_reg_write  <= 1'b0;
            r_mem_mem_to_reg <= 1'b0;
            r_mem_misalign   <= 1'b0;
        end else if (w_load) begin
            r_mem_valid      <= bus.ex_valid;
            r_mem_mem_read   <= w_mem_read;
            r_mem_mem_write  <= w_mem_write;
            r_mem_reg_write  <= w_reg_write;
            r_mem_mem_to_reg <= bus.ex_mem_to_reg;
            r_mem_alu_result <= bus.ex_alu_result;
            r_mem_store_data <= w_store_data;
            r_mem_rd_addr    <= bus.ex_rd_addr;
            r_mem_pc_plus2   <= bus.ex_pc_plus2;
            r_mem_misalign   <= w_misalign;
            r_halted         <= w_halt_set;
        end
    end

    assign bus.mem_valid      = r_mem_valid;
    assign bus.mem_mem_read   = r_mem_mem_read;
    assign bus.mem_mem_write  = r_mem_mem_write;
    assign bus.mem_reg_write  = r_mem_reg_write;
    assign bus.mem_mem_to_reg = r_mem_mem_to_reg;
    assign bus.mem_alu_result = r_mem_alu_result;
    assign bus.mem_store_data = r_mem_store_data;
    assign bus.mem_rd_addr    = r_mem_rd_addr;
    assign bus.mem_pc_plus2   = r_mem_pc_plus2;
    assign bus.mem_misalign   = r_mem_misalign;
    assign bus.halted         = r_halted;
endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios plus randomized traffic against a rule-level model.
module tb_ex_mem_reg;
    localparam int DW = 16;
    localparam int RW = 4;

    typedef struct packed {
        logic          valid;
        logic          rd;
        logic          wr;
        logic          rw;
        logic          m2r;
        logic          mis;
        logic          halted;
        logic [RW-1:0] rd_addr;
        logic [DW-1:0] alu;
        logic [DW-1:0] sd;
        logic [DW-1:0] pc;
    } obs_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    obs_t exp_s;
    obs_t got;

    ex_mem_reg_if #(.DW(DW), .RW(RW)) bus ();

    ex_mem_reg #(.DW(DW), .RW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t get_obs();
        obs_t o;
        o.valid   = bus.mem_valid;
        o.rd      = bus.mem_mem_read;
        o.wr      = bus.mem_mem_write;
        o.rw      = bus.mem_reg_write;
        o.m2r     = bus.mem_mem_to_reg;
        o.mis     = bus.mem_misalign;
        o.halted  = bus.halted;
        o.rd_addr = bus.mem_rd_addr;
        o.alu     = bus.mem_alu_result;
        o.sd      = bus.mem_store_data;
        o.pc      = bus.mem_pc_plus2;
        return o;
    endfunction

    // Rule-level model of what the MEM slot should hold after the coming edge.
    function automatic obs_t model_next(obs_t s);
        obs_t n = s;
        logic fwd;
        if (rst) begin
            n = '0;
        end else if (bus.flush) begin
            n.valid = 0; n.rd = 0; n.wr = 0; n.rw = 0; n.m2r = 0; n.mis = 0;
        end else if (!bus.stall && !s.halted) begin
            n.valid   = bus.ex_valid;
            n.rd      = bus.ex_valid && bus.ex_mem_read;
            n.wr      = bus.ex_valid && bus.ex_mem_write;
            n.rw      = bus.ex_valid && bus.ex_reg_write && bus.ex_rd_addr != 0;
            n.m2r     = bus.ex_mem_to_reg;
            n.mis     = bus.ex_valid && (bus.ex_mem_read || bus.ex_mem_write) && (bus.ex_alu_result % 2 == 1);
            n.halted  = bus.ex_valid && bus.ex_halt;
            n.rd_addr = bus.ex_rd_addr;
            n.alu     = bus.ex_alu_result;
            n.pc      = bus.ex_pc_plus2;
`ifdef EXMEM_STORE_FWD_EN
            fwd = bus.wb_reg_write && bus.wb_rd_addr == bus.ex_rt_addr && bus.ex_rt_addr != 0 && bus.ex_mem_write;
`else
            fwd = 1'b0;
`endif
            n.sd      = fwd ? bus.wb_data : bus.ex_rt_data;
        end
        return n;
    endfunction

    task automatic tick();
        exp_s = model_next(exp_s);
        @(posedge clk);
        #1;
        got = get_obs();
    endtask

    task automatic rand_ex();
        bus.ex_valid      = 1'($urandom);
        bus.ex_alu_result = DW'($urandom);
        bus.ex_rt_data    = DW'($urandom);
        bus.ex_rt_addr    = RW'($urandom);
        bus.ex_rd_addr    = RW'($urandom);
        bus.ex_mem_read   = 1'($urandom);
        bus.ex_mem_write  = 1'($urandom);
        bus.ex_reg_write  = 1'($urandom);
        bus.ex_mem_to_reg = 1'($urandom);
        bus.ex_halt       = ($urandom_range(0, 15) == 0);
        bus.ex_pc_plus2   = DW'($urandom);
        bus.wb_reg_write  = 1'($urandom);
        bus.wb_rd_addr    = RW'($urandom);
        bus.wb_data       = DW'($urandom);
    endtask

    task automatic test_reset();
        rst = 1; bus.stall = 0; bus.flush = 0;
        bus.ex_valid = 1; bus.ex_alu_result = '1; bus.ex_rt_data = '1; bus.ex_rt_addr = '1;
        bus.ex_rd_addr = '1; bus.ex_mem_read = 1; bus.ex_mem_write = 1; bus.ex_reg_write = 1;
        bus.ex_mem_to_reg = 1; bus.ex_halt = 1; bus.ex_pc_plus2 = '1;
        bus.wb_reg_write = 1; bus.wb_rd_addr = '1; bus.wb_data = '1;
        tick();
        total++;
        if (got !== obs_t'(0)) begin bad++; $display("FAIL reset_all: got %h want 0", got); end
        total++;
        if (got.halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", got.halted); end
        rst = 0;
    endtask

    task automatic test_store();
        rand_ex();
        bus.ex_valid = 1; bus.ex_mem_write = 1; bus.ex_mem_read = 0; bus.ex_halt = 0;
        bus.ex_alu_result = 16'h0040; bus.ex_rt_data = 16'h1234; bus.wb_reg_write = 0;
        tick();
        total++;
        if (got.wr !== 1'b1) begin bad++; $display("FAIL store_wr: got %b want 1", got.wr); end
        total++;
        if (got.alu !== 16'h0040) begin bad++; $display("FAIL store_alu: got %h want 0040", got.alu); end
        total++;
        if (got.sd !== 16'h1234) begin bad++; $display("FAIL store_data: got %h want 1234", got.sd); end
        total++;
        if (got.mis !== 1'b0) begin bad++; $display("FAIL store_mis: got %b want 0", got.mis); end
    endtask

    task automatic test_stall();
        rand_ex();
        bus.ex_valid = 1; bus.ex_mem_read = 1; bus.ex_halt = 0; bus.ex_alu_result = 16'h0041;
        tick();
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            rand_ex();
            bus.ex_alu_result = 16'h0100 + 16'(i);
            tick();
            total++;
            if (got.alu !== 16'h0041) begin bad++; $display("FAIL stall_alu[%0d]: got %h want 0041", i, got.alu); end
            total++;
            if (got.mis !== 1'b1 || got.rd !== 1'b1) begin
                bad++; $display("FAIL stall_ctl[%0d]: got mis=%b rd=%b want 1 1", i, got.mis, got.rd);
            end
        end
        bus.stall = 0;
    endtask

    task automatic test_flush_stall();
        logic [DW-1:0] held;
        rand_ex();
        bus.ex_valid = 1; bus.ex_reg_write = 1; bus.ex_rd_addr = 5; bus.ex_mem_write = 1; bus.ex_halt = 0;
        tick();
        held = got.alu;
        rand_ex();
        bus.ex_halt = 0; bus.stall = 1; bus.flush = 1;
        tick();
        total++;
        if ({got.valid, got.rd, got.wr, got.rw, got.m2r, got.mis} !== 6'b0) begin
            bad++; $display("FAIL flush_ctl: got %b want 000000", {got.valid, got.rd, got.wr, got.rw, got.m2r, got.mis});
        end
        total++;
        if (got.alu !== held) begin bad++; $display("FAIL flush_data_hold: got %h want %h", got.alu, held); end
        bus.stall = 0; bus.flush = 0;
        rand_ex();
        bus.ex_valid = 1; bus.ex_reg_write = 1; bus.ex_rd_addr = 0; bus.ex_halt = 0;
        tick();
        total++;
        if (got.rw !== 1'b0 || got.valid !== 1'b1) begin
            bad++; $display("FAIL r0_write: got rw=%b valid=%b want 0 1", got.rw, got.valid);
        end
    endtask

    task automatic test_halt();
        rand_ex();
        bus.ex_valid = 1; bus.ex_halt = 1; bus.ex_alu_result = 16'h0100;
        tick();
        total++;
        if (got.halted !== 1'b1 || got.alu !== 16'h0100) begin
            bad++; $display("FAIL halt_set: got halted=%b alu=%h want 1 0100", got.halted, got.alu);
        end
        for (int i = 0; i < 3; i++) begin
            rand_ex();
            bus.ex_halt = 0; bus.ex_alu_result = 16'h0200 + 16'(i);
            tick();
            total++;
            if (got.halted !== 1'b1 || got.alu !== 16'h0100) begin
                bad++; $display("FAIL halt_hold[%0d]: got halted=%b alu=%h want 1 0100", i, got.halted, got.alu);
            end
        end
        rst = 1;
        tick();
        total++;
        if (got.halted !== 1'b0) begin bad++; $display("FAIL halt_clear: got %b want 0", got.halted); end
        rst = 0;
    endtask

    task automatic test_reset_mid_stall();
        rand_ex();
        rst = 1; bus.stall = 1; bus.flush = 1;
        tick();
        total++;
        if (got !== obs_t'(0)) begin bad++; $display("FAIL rst_over_stall: got %h want 0", got); end
        rst = 0; bus.flush = 0; bus.stall = 0;
        rand_ex();
        bus.ex_halt = 0; bus.ex_alu_result = 16'h5A5A;
        tick();
        total++;
        if (got.alu !== 16'h5A5A) begin bad++; $display("FAIL load_after_rst: got %h want 5a5a", got.alu); end
    endtask

    task automatic test_store_fwd();
        logic [DW-1:0] want;
`ifdef EXMEM_STORE_FWD_EN
        want = 16'hBEEF;
`else
        want = 16'h1111;
`endif
        rand_ex();
        bus.ex_valid = 1; bus.ex_mem_write = 1; bus.ex_halt = 0; bus.ex_rt_addr = 3; bus.ex_rt_data = 16'h1111;
        bus.wb_reg_write = 1; bus.wb_rd_addr = 3; bus.wb_data = 16'hBEEF;
        tick();
        total++;
        if (got.sd !== want) begin bad++; $display("FAIL fwd_rt3: got %h want %h", got.sd, want); end
        bus.ex_rt_addr = 0; bus.wb_rd_addr = 0;
        tick();
        total++;
        if (got.sd !== 16'h1111) begin bad++; $display("FAIL fwd_rt0: got %h want 1111", got.sd); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_ex();
            rst       = ($urandom_range(0, 39) == 0);
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.wb_rd_addr = bus.ex_rt_addr;
            end
            tick();
            total++;
            if (got !== exp_s) begin bad++; $display("FAIL random[%0d]: got %h want %h", i, got, exp_s); end
        end
        rst = 0; bus.stall = 0; bus.flush = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_s = '0;
        rst   = 1;
        bus.stall = 0;
        bus.flush = 0;
        rand_ex();
        test_reset();
        test_store();
        test_stall();
        test_flush_stall();
        test_halt();
        test_reset_mid_stall();
        test_store_fwd();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Parameter DW, default 16: datapath width (ALU result, store data, PC).
REQ-002 Parameter RW, default 4: register-address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  hold all MEM-side state this cycle.
REQ-006 flush  input  1  insert bubble into MEM slot.
REQ-007 ex_valid  input  1  EX slot holds a real instruction.
REQ-008 ex_alu_result  input  DW  address for LW/SW, or ALU result.
REQ-009 ex_rt_data  input  DW  store data from rt.
REQ-010 ex_rt_addr, ex_rd_addr  input  RW each  store-source and destination register numbers.
REQ-011 ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_halt  input  1 each  control bits.
REQ-012 ex_pc_plus2  input  DW  PC+2 of EX instruction.
REQ-013 wb_reg_write  input  1, wb_rd_addr  input  RW, wb_data  input  DW  MEM/WB writeback bus for store-data forwarding.
REQ-014 mem_valid, mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg  output  1 each  registered controls.
REQ-015 mem_alu_result  output  DW, mem_store_data  output  DW, mem_rd_addr  output  RW, mem_pc_plus2  output  DW  registered data.
REQ-016 mem_misalign  output  1  registered memory op with odd address.
REQ-017 halted  output  1  sticky; a HLT has reached MEM.

Function
REQ-018 Priority per edge: rst > flush > stall > load.
REQ-019 Load (no rst/flush/stall): every mem_* register captures its ex_* counterpart; one-cycle latency.
REQ-020 Control outputs are qualified: mem_mem_read/mem_mem_write/mem_reg_write are 1 only if ex_valid was 1 at capture.
REQ-021 mem_reg_write forced 0 when ex_rd_addr == 0 (R0 hardwired zero).
REQ-022 Flush: mem_valid and all control outputs become 0; data registers hold; halted unaffected.
REQ-023 Stall: all registers hold; the forwarded store-data register also holds.
REQ-024 Flush and stall together: flush wins; bubble inserted.
REQ-025 mem_misalign captures ex_valid & (ex_mem_read | ex_mem_write) & ex_alu_result[0]; cleared by flush.
REQ-026 halted sets on a load with ex_valid & ex_halt; remains 1 until rst; once set, further loads ignored (registers hold) until rst.
REQ-027 Store data selection at capture: ex_rt_data, unless forwarding applies (REQ-032).
REQ-028 No arithmetic performed; all widths pass through unchanged, no truncation or extension.

Reset
REQ-029 On rst at a clock edge: all outputs 0, including halted, mem_misalign, all data registers.
REQ-030 Reset mid-stall or mid-flush: reset wins; the next non-reset edge performs a normal load.
REQ-031 Outputs are undefined only before the first reset edge; no asynchronous behaviour.

Configuration
REQ-032 Macro EXMEM_STORE_FWD_EN defined: at load, if wb_reg_write & (wb_rd_addr == ex_rt_addr) & (ex_rt_addr != 0) & ex_mem_write, mem_store_data captures wb_data instead of ex_rt_data.
REQ-033 Macro undefined: mem_store_data always captures ex_rt_data; wb_* inputs present but unused; no extra logic.

Verification
REQ-034 rst=1 one edge with all ex_* = 1s -> all outputs 0, halted=0.
REQ-035 ex_valid=1, ex_mem_write=1, ex_alu_result=0x0040, ex_rt_data=0x1234 -> next cycle mem_mem_write=1, mem_alu_result=0x0040, mem_store_data=0x1234, mem_misalign=0.
REQ-036 Load with ex_alu_result=0x0041, ex_mem_read=1, then stall=1 for 3 cycles with new ex_* values -> outputs hold 0x0041 and mem_misalign=1 for all 3 cycles.
REQ-037 stall=1 and flush=1 same edge -> mem_valid=0, all controls 0; ex_rd_addr=0 with ex_reg_write=1 -> mem_reg_write=0.
REQ-038 ex_halt=1 ex_valid=1 load -> halted=1; subsequent loads with different ex_alu_result -> outputs unchanged; rst -> halted=0.
REQ-039 With EXMEM_STORE_FWD_EN: ex_mem_write=1, ex_rt_addr=3, ex_rt_data=0x1111, wb_reg_write=1, wb_rd_addr=3, wb_data=0xBEEF -> mem_store_data=0xBEEF; without macro -> 0x1111; with ex_rt_addr=0 -> 0x1111 in both builds.
